// File: rtl/contador_programa.sv
// -----------------------------------------------------------------------------
// contador_programa
//   Program-counter register stage of the nRISC fetch path. Holds the current
//   PC, which feeds the instruction memory and the +1 adder (somadorpc). The
//   next PC is chosen from the adder result, a PC-relative branch target, an
//   absolute jump target, or the held value (stall/halt). A two-state RUN/HALT
//   machine gates fetching. Redirects are reported so decode can squash the
//   instruction that was already fetched.
//
//   Optional feature macro: CONTADOR_LINK_EN
//     When defined, adds link_en_i / link_addr_o. An accepted jump with
//     link_en_i=1 captures pc_inc_i (the return address) into link_addr_o.
//
// Ports
//   clk_i           clock, all state changes on the rising edge
//   rst_i           synchronous active-high reset
//   pc_inc_i        PC+1 from the external adder
//   stall_i         hold PC this cycle
//   branch_taken_i  conditional branch resolved taken
//   branch_off_i    signed branch offset relative to the current PC
//   jump_en_i       unconditional absolute jump
//   jump_addr_i     jump target
//   halt_i          halt request
//   resume_i        leave HALT
//   pc_o            current PC (registered)
//   pc_valid_o      pc_o is a fetchable address this cycle
//   redirect_o      pc_o was loaded from a branch/jump at the last edge
//   halted_o        machine is in HALT
//   link_en_i       (CONTADOR_LINK_EN) capture return address on jump
//   link_addr_o     (CONTADOR_LINK_EN) captured return address
// -----------------------------------------------------------------------------
module contador_programa #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [PC_W-1:0] pc_inc_i,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic [PC_W-1:0] branch_off_i,
    input  logic            jump_en_i,
    input  logic [PC_W-1:0] jump_addr_i,
    input  logic            halt_i,
    input  logic            resume_i,
    output logic [PC_W-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            redirect_o,
    output logic            halted_o
`ifdef CONTADOR_LINK_EN
    ,
    input  logic            link_en_i,
    output logic [PC_W-1:0] link_addr_o
`endif
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            redirect_q, redirect_d;
    logic            halted_q, halted_d;
    logic [PC_W-1:0] branch_tgt_s;
`ifdef CONTADOR_LINK_EN
    logic [PC_W-1:0] link_q, link_d;
`endif

    // Two's-complement add; the carry out is dropped so the target wraps mod 2^PC_W.
    assign branch_tgt_s = pc_q + branch_off_i;

    // Next-state selection: halt > jump > branch > stall > increment while running.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = 1'b1;
        redirect_d = 1'b0;
        halted_d   = 1'b0;
`ifdef CONTADOR_LINK_EN
        link_d     = link_q;
`endif
        case (state_q)
            ST_RUN: begin
                if (halt_i) begin
                    // The halting instruction's address is kept, not advanced.
                    state_d  = ST_HALT;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end else if (jump_en_i) begin
                    pc_d       = jump_addr_i;
                    redirect_d = 1'b1;
                    valid_d    = 1'b0;
`ifdef CONTADOR_LINK_EN
                    if (link_en_i) begin
                        link_d = pc_inc_i;
                    end else begin
                        link_d = link_q;
                    end
`endif
                end else if (branch_taken_i) begin
                    pc_d       = branch_tgt_s;
                    redirect_d = 1'b1;
                    valid_d    = 1'b0;
                end else if (stall_i) begin
                    pc_d = pc_q;
                end else begin
                    pc_d = pc_inc_i;
                end
            end
            ST_HALT: begin
                // Resuming restarts fetch at the held PC; no increment is applied.
                if (resume_i) begin
                    state_d = ST_RUN;
                end else begin
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
                pc_d    = RESET_PC;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b1;
            redirect_q <= 1'b0;
            halted_q   <= 1'b0;
`ifdef CONTADOR_LINK_EN
            link_q     <= RESET_PC;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            redirect_q <= redirect_d;
            halted_q   <= halted_d;
`ifdef CONTADOR_LINK_EN
            link_q     <= link_d;
`endif
        end
    end

    assign pc_o       = pc_q;
    assign pc_valid_o = valid_q;
    assign redirect_o = redirect_q;
    assign halted_o   = halted_q;
`ifdef CONTADOR_LINK_EN
    assign link_addr_o = link_q;
`endif

endmodule

// File: tb/tb_contador_programa.sv
// -----------------------------------------------------------------------------
// tb_contador_programa
//   Directed scenarios followed by randomized stimulus, all compared against a
//   behavioural model of the program counter. The +1 adder is modelled by the
//   bench and attached to pc_inc_i.
// -----------------------------------------------------------------------------
module tb_contador_programa;

    localparam int         PC_W     = 8;
    localparam logic [7:0] RESET_PC = 8'h00;

    logic       clk_i = 1'b0;
    logic       rst_i, stall_i, branch_taken_i, jump_en_i, halt_i, resume_i;
    logic [7:0] pc_inc_i, branch_off_i, jump_addr_i, pc_o;
    logic       pc_valid_o, redirect_o, halted_o;
`ifdef CONTADOR_LINK_EN
    logic       link_en_i = 1'b0;
    logic [7:0] link_addr_o;
    logic [7:0] m_link;
`endif

    // Model state
    logic [7:0] m_pc;
    logic       m_halted, m_redirect, m_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    // External +1 adder
    assign pc_inc_i = pc_o + 8'd1;

    contador_programa #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .pc_inc_i       (pc_inc_i),
        .stall_i        (stall_i),
        .branch_taken_i (branch_taken_i),
        .branch_off_i   (branch_off_i),
        .jump_en_i      (jump_en_i),
        .jump_addr_i    (jump_addr_i),
        .halt_i         (halt_i),
        .resume_i       (resume_i),
        .pc_o           (pc_o),
        .pc_valid_o     (pc_valid_o),
        .redirect_o     (redirect_o),
        .halted_o       (halted_o)
`ifdef CONTADOR_LINK_EN
        ,
        .link_en_i      (link_en_i),
        .link_addr_o    (link_addr_o)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one set of inputs across one rising edge, advance the model, compare.
    task automatic cyc(input logic r, input logic s, input logic b, input logic [7:0] off,
                       input logic j, input logic [7:0] a, input logic h, input logic res);
        logic [7:0] inc;
        rst_i = r; stall_i = s; branch_taken_i = b; branch_off_i = off;
        jump_en_i = j; jump_addr_i = a; halt_i = h; resume_i = res;
        inc = m_pc + 8'd1;
        @(posedge clk_i);
        #1;
        if (r) begin
            m_pc = RESET_PC; m_halted = 1'b0; m_redirect = 1'b0; m_valid = 1'b1;
`ifdef CONTADOR_LINK_EN
            m_link = RESET_PC;
`endif
        end else if (m_halted) begin
            m_redirect = 1'b0;
            m_halted   = !res;
            m_valid    = res;
        end else if (h) begin
            m_halted = 1'b1; m_valid = 1'b0; m_redirect = 1'b0;
        end else if (j || b) begin
`ifdef CONTADOR_LINK_EN
            if (j && link_en_i) m_link = inc;
`endif
            m_pc = j ? a : 8'((int'(m_pc) + int'(off)) % 256);
            m_redirect = 1'b1; m_valid = 1'b0;
        end else begin
            if (!s) m_pc = inc;
            m_redirect = 1'b0; m_valid = 1'b1;
        end
        check_eq("pc",       {24'd0, pc_o},       {24'd0, m_pc});
        check_eq("pc_valid", {31'd0, pc_valid_o}, {31'd0, m_valid});
        check_eq("redirect", {31'd0, redirect_o}, {31'd0, m_redirect});
        check_eq("halted",   {31'd0, halted_o},   {31'd0, m_halted});
`ifdef CONTADOR_LINK_EN
        check_eq("link_addr", {24'd0, link_addr_o}, {24'd0, m_link});
`endif
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic jump_to(input logic [7:0] a);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, a, 1'b0, 1'b0);
    endtask

    initial begin
        m_pc = 8'hxx; m_halted = 1'b0; m_redirect = 1'b0; m_valid = 1'b1;
`ifdef CONTADOR_LINK_EN
        m_link = RESET_PC;
`endif
        // 1: reset then free-running
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("t1_reset_pc", {24'd0, pc_o}, 32'h00);
        for (int i = 0; i < 4; i++) idle();
        check_eq("t1_pc4",    {24'd0, pc_o}, 32'h04);
        check_eq("t1_valid",  {31'd0, pc_valid_o}, 32'd1);

        // 2: stall hold, then adder wrap
        jump_to(8'h10);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("t2_stall", {24'd0, pc_o}, 32'h10);
        idle();
        check_eq("t2_inc", {24'd0, pc_o}, 32'h11);
        jump_to(8'hFF);
        idle();
        check_eq("t2_wrap", {24'd0, pc_o}, 32'h00);

        // 3: negative branch with bubble
        jump_to(8'h20);
        cyc(1'b0, 1'b0, 1'b1, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("t3_pc",       {24'd0, pc_o}, 32'h10);
        check_eq("t3_redirect", {31'd0, redirect_o}, 32'd1);
        check_eq("t3_bubble",   {31'd0, pc_valid_o}, 32'd0);
        idle();
        check_eq("t3_redirect_clr", {31'd0, redirect_o}, 32'd0);
        check_eq("t3_valid_back",   {31'd0, pc_valid_o}, 32'd1);
        // branch arithmetic wrap
        jump_to(8'h02);
        cyc(1'b0, 1'b0, 1'b1, 8'hFC, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("t3_br_wrap", {24'd0, pc_o}, 32'hFE);

        // 4: jump beats branch and stall
        jump_to(8'h30);
        cyc(1'b0, 1'b1, 1'b1, 8'h05, 1'b1, 8'h80, 1'b0, 1'b0);
        check_eq("t4_pc",       {24'd0, pc_o}, 32'h80);
        check_eq("t4_redirect", {31'd0, redirect_o}, 32'd1);

        // 5: halt holds PC despite jumps; resume restarts at held PC
        jump_to(8'h40);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("t5_halted", {31'd0, halted_o}, 32'd1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hAA, 1'b0, 1'b0);
        check_eq("t5_hold", {24'd0, pc_o}, 32'h40);
        check_eq("t5_invalid", {31'd0, pc_valid_o}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("t5_resumed", {31'd0, halted_o}, 32'd0);
        idle();
        check_eq("t5_pc41", {24'd0, pc_o}, 32'h41);
        // halt and resume together in RUN: halt wins
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
        check_eq("t5_halt_wins", {31'd0, halted_o}, 32'd1);

        // 6: reset while halted with a jump pending
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b0);
        check_eq("t6_pc",       {24'd0, pc_o}, {24'd0, RESET_PC});
        check_eq("t6_halted",   {31'd0, halted_o}, 32'd0);
        check_eq("t6_redirect", {31'd0, redirect_o}, 32'd0);

`ifdef CONTADOR_LINK_EN
        jump_to(8'h50);
        link_en_i = 1'b1;
        jump_to(8'h90);
        link_en_i = 1'b0;
        check_eq("t7_pc",   {24'd0, pc_o}, 32'h90);
        check_eq("t7_link", {24'd0, link_addr_o}, 32'h51);
`endif

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
`ifdef CONTADOR_LINK_EN
            link_en_i = ($urandom_range(0, 1) == 0);
`endif
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 5) == 0),
                8'($urandom_range(0, 255)),
                ($urandom_range(0, 7) == 0),
                8'($urandom_range(0, 255)),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 2) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
